// File: rtl/execute_cc_stage.sv
// Y86 execute stage: ALU, registered condition codes, cmov/jXX evaluation and E->M pipeline register.
// Define EXEC_MUL_EN to add a multi-cycle mulq (OPq ifun 4) that stalls the front end via e_busy.
module execute_cc_stage #(
   parameter int unsigned W          = 64,
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   E_stat,
   input  logic [3:0]   E_icode,
   input  logic [3:0]   E_ifun,
   input  logic [W-1:0] E_valA,
   input  logic [W-1:0] E_valB,
   input  logic [W-1:0] E_valC,
   input  logic [3:0]   E_dstE,
   input  logic [3:0]   E_dstM,
   input  logic         set_cc,
   input  logic         M_stall,
   input  logic         M_bubble,
   output logic [W-1:0] e_valE,
   output logic [3:0]   e_dstE,
   output logic         e_busy,
   output logic         zf,
   output logic         sf,
   output logic         of,
   output logic [1:0]   M_stat,
   output logic [3:0]   M_icode,
   output logic         M_cnd,
   output logic [W-1:0] M_valE,
   output logic [W-1:0] M_valA,
   output logic [3:0]   M_dstE,
   output logic [3:0]   M_dstM
);

   typedef enum logic [1:0] {
      S_AOK = 2'b00,
      S_HLT = 2'b01,
      S_ADR = 2'b10,
      S_INS = 2'b11
   } stat_e;

   typedef enum logic [3:0] {
      I_HALT  = 4'h0,
      I_NOP   = 4'h1,
      I_CMOV  = 4'h2,
      I_IRMOV = 4'h3,
      I_RMMOV = 4'h4,
      I_MRMOV = 4'h5,
      I_OPQ   = 4'h6,
      I_JXX   = 4'h7,
      I_CALL  = 4'h8,
      I_RET   = 4'h9,
      I_PUSH  = 4'hA,
      I_POP   = 4'hB
   } icode_e;

   localparam logic [3:0]   REG_NONE = 4'hF;
   localparam logic [W-1:0] STACK_INC = W'(8);

   if (W < 8 || MUL_CYCLES < 2) begin : g_param_check
      $error("execute_cc_stage: W must be >= 8 and MUL_CYCLES >= 2");
   end

   logic         op_valid;
   logic         op_is_mul;
   logic         is_cond;
   logic         cnd;
   logic         ifun_bad;
   logic         cc_en;
   logic         new_of;
   logic [W-1:0] mul_lo;
   logic         mul_of;
   stat_e        stat_out;

`ifdef EXEC_MUL_EN
   localparam int unsigned CW = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

   logic [CW-1:0]  mul_cnt;
   logic [2*W-1:0] mul_full;

   // Sign-extended operands make the low 2W bits of the unsigned product equal the signed product.
   assign mul_full  = {{W{E_valB[W-1]}}, E_valB} * {{W{E_valA[W-1]}}, E_valA};
   assign mul_lo    = mul_full[W-1:0];
   assign mul_of    = (mul_full[2*W-1:W] != {W{mul_full[W-1]}});
   assign op_is_mul = (E_icode == I_OPQ) && (E_ifun == 4'd4);
   assign op_valid  = (E_ifun <= 4'd4);
   assign e_busy    = op_is_mul && (mul_cnt != CNT_LAST);

   // Counter parks on its last value while M is stalled so the result is not lost.
   always_ff @(posedge clk) begin
      if (rst)
         mul_cnt <= '0;
      else if (e_busy)
         mul_cnt <= mul_cnt + 1'b1;
      else if (!M_stall || !op_is_mul)
         mul_cnt <= '0;
   end
`else
   assign mul_lo    = '0;
   assign mul_of    = 1'b0;
   assign op_is_mul = 1'b0;
   assign op_valid  = (E_ifun <= 4'd3);
   assign e_busy    = 1'b0;
`endif

   always_comb begin
      e_valE = '0;
      new_of = 1'b0;
      case (E_icode)
         I_CMOV:           e_valE = E_valA;
         I_IRMOV:          e_valE = E_valC;
         I_RMMOV, I_MRMOV: e_valE = E_valB + E_valC;
         I_OPQ: begin
            case (E_ifun)
               4'd0: begin
                  e_valE = E_valB + E_valA;
                  new_of = (E_valA[W-1] == E_valB[W-1]) && (e_valE[W-1] != E_valB[W-1]);
               end
               4'd1: begin
                  e_valE = E_valB - E_valA;
                  new_of = (E_valA[W-1] != E_valB[W-1]) && (e_valE[W-1] != E_valB[W-1]);
               end
               4'd2: e_valE = E_valB & E_valA;
               4'd3: e_valE = E_valB ^ E_valA;
               4'd4: begin
                  if (op_is_mul) begin
                     e_valE = mul_lo;
                     new_of = mul_of;
                  end
               end
               default: e_valE = '0;
            endcase
         end
         I_CALL, I_PUSH:   e_valE = E_valB - STACK_INC;
         I_RET, I_POP:     e_valE = E_valB + STACK_INC;
         default:          e_valE = '0;
      endcase
   end

   assign is_cond = (E_icode == I_CMOV) || (E_icode == I_JXX);

   always_comb begin
      cnd = 1'b0;
      if (is_cond) begin
         case (E_ifun)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = (sf ^ of) | zf;
            4'd2:    cnd = sf ^ of;
            4'd3:    cnd = zf;
            4'd4:    cnd = ~zf;
            4'd5:    cnd = ~(sf ^ of);
            4'd6:    cnd = ~((sf ^ of) | zf);
            default: cnd = 1'b0;
         endcase
      end
   end

   assign ifun_bad = (is_cond && (E_ifun > 4'd6)) || ((E_icode == I_OPQ) && !op_valid);
   assign stat_out = ((stat_e'(E_stat) == S_AOK) && ifun_bad) ? S_INS : stat_e'(E_stat);

   always_comb begin
      e_dstE = E_dstE;
      if (((E_icode == I_CMOV) && !cnd) || ((E_icode == I_OPQ) && !op_valid))
         e_dstE = REG_NONE;
   end

   assign cc_en = (E_icode == I_OPQ) && op_valid && set_cc &&
                  (stat_e'(E_stat) == S_AOK) && !e_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         zf <= 1'b1;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (cc_en) begin
         zf <= (e_valE == '0);
         sf <= e_valE[W-1];
         of <= new_of;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || (!M_stall && (e_busy || M_bubble))) begin
         M_stat  <= S_AOK;
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= REG_NONE;
         M_dstM  <= REG_NONE;
      end else if (!M_stall) begin
         M_stat  <= stat_out;
         M_icode <= E_icode;
         M_cnd   <= cnd;
         M_valE  <= e_valE;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed bench for execute_cc_stage: a W=64 instance for the main sequence and a W=16 instance.
module tb_execute_cc_stage;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // W=64 instance signals
   logic [1:0]  a_stat;
   logic [3:0]  a_icode, a_ifun, a_dstE, a_dstM;
   logic [63:0] a_valA, a_valB, a_valC;
   logic        a_set_cc, a_M_stall, a_M_bubble;
   logic [63:0] a_e_valE, a_M_valE, a_M_valA;
   logic [3:0]  a_e_dstE, a_M_icode, a_M_dstE, a_M_dstM;
   logic        a_e_busy, a_zf, a_sf, a_of, a_M_cnd;
   logic [1:0]  a_M_stat;

   // W=16 instance signals
   logic [1:0]  b_stat;
   logic [3:0]  b_icode, b_ifun, b_dstE, b_dstM;
   logic [15:0] b_valA, b_valB, b_valC;
   logic        b_set_cc, b_M_stall, b_M_bubble;
   logic [15:0] b_e_valE, b_M_valE, b_M_valA;
   logic [3:0]  b_e_dstE, b_M_icode, b_M_dstE, b_M_dstM;
   logic        b_e_busy, b_zf, b_sf, b_of, b_M_cnd;
   logic [1:0]  b_M_stat;

   execute_cc_stage #(.W(64), .MUL_CYCLES(4)) u64 (
      .clk(clk), .rst(rst), .E_stat(a_stat), .E_icode(a_icode), .E_ifun(a_ifun),
      .E_valA(a_valA), .E_valB(a_valB), .E_valC(a_valC), .E_dstE(a_dstE), .E_dstM(a_dstM),
      .set_cc(a_set_cc), .M_stall(a_M_stall), .M_bubble(a_M_bubble),
      .e_valE(a_e_valE), .e_dstE(a_e_dstE), .e_busy(a_e_busy),
      .zf(a_zf), .sf(a_sf), .of(a_of),
      .M_stat(a_M_stat), .M_icode(a_M_icode), .M_cnd(a_M_cnd), .M_valE(a_M_valE),
      .M_valA(a_M_valA), .M_dstE(a_M_dstE), .M_dstM(a_M_dstM)
   );

   execute_cc_stage #(.W(16), .MUL_CYCLES(4)) u16 (
      .clk(clk), .rst(rst), .E_stat(b_stat), .E_icode(b_icode), .E_ifun(b_ifun),
      .E_valA(b_valA), .E_valB(b_valB), .E_valC(b_valC), .E_dstE(b_dstE), .E_dstM(b_dstM),
      .set_cc(b_set_cc), .M_stall(b_M_stall), .M_bubble(b_M_bubble),
      .e_valE(b_e_valE), .e_dstE(b_e_dstE), .e_busy(b_e_busy),
      .zf(b_zf), .sf(b_sf), .of(b_of),
      .M_stat(b_M_stat), .M_icode(b_M_icode), .M_cnd(b_M_cnd), .M_valE(b_M_valE),
      .M_valA(b_M_valA), .M_dstE(b_M_dstE), .M_dstM(b_M_dstM)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                          input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                          input logic [3:0] de, input logic [3:0] dm);
      a_stat = st; a_icode = ic; a_ifun = fn;
      a_valA = va; a_valB = vb; a_valC = vc;
      a_dstE = de; a_dstM = dm;
   endtask

   task automatic drive_b(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                          input logic [15:0] va, input logic [15:0] vb, input logic [3:0] de);
      b_stat = st; b_icode = ic; b_ifun = fn;
      b_valA = va; b_valB = vb; b_valC = '0;
      b_dstE = de; b_dstM = 4'hF;
   endtask

   initial begin
      rst = 1'b1;
      drive_a(2'b00, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
      drive_b(2'b00, 4'h1, 4'h0, '0, '0, 4'hF);
      a_set_cc = 1'b0; a_M_stall = 1'b0; a_M_bubble = 1'b0;
      b_set_cc = 1'b0; b_M_stall = 1'b0; b_M_bubble = 1'b0;
      step();
      step();
      rst = 1'b0;

      chk("rst_M_icode", 64'(a_M_icode), 64'h1);
      chk("rst_M_dstE",  64'(a_M_dstE),  64'hF);
      chk("rst_M_dstM",  64'(a_M_dstM),  64'hF);
      chk("rst_M_valE",  a_M_valE,       64'h0);
      chk("rst_zf",      64'(a_zf),      64'h1);
      chk("rst_sf",      64'(a_sf),      64'h0);
      chk("rst_of",      64'(a_of),      64'h0);
      chk("rst_busy",    64'(a_e_busy),  64'h0);

      // addq overflow into the sign bit
      a_set_cc = 1'b1;
      drive_a(2'b00, 4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h3, 4'hF);
      step();
      chk("add_M_valE", a_M_valE, 64'h8000_0000_0000_0000);
      chk("add_M_icode", 64'(a_M_icode), 64'h6);
      chk("add_zf", 64'(a_zf), 64'h0);
      chk("add_sf", 64'(a_sf), 64'h1);
      chk("add_of", 64'(a_of), 64'h1);

      drive_a(2'b00, 4'h7, 4'h2, '0, '0, 64'h40, 4'hF, 4'hF);
      step();
      chk("jl_M_cnd", 64'(a_M_cnd), 64'h0);
      drive_a(2'b00, 4'h7, 4'h5, '0, '0, 64'h40, 4'hF, 4'hF);
      step();
      chk("jge_M_cnd", 64'(a_M_cnd), 64'h1);

      // subq with set_cc low must leave CC alone
      a_set_cc = 1'b0;
      drive_a(2'b00, 4'h6, 4'h1, 64'h5, 64'h5, '0, 4'h2, 4'hF);
      step();
      chk("sub_nocc_M_valE", a_M_valE, 64'h0);
      chk("sub_nocc_zf", 64'(a_zf), 64'h0);
      chk("sub_nocc_sf", 64'(a_sf), 64'h1);
      chk("sub_nocc_of", 64'(a_of), 64'h1);
      a_set_cc = 1'b1;
      step();
      chk("sub_cc_zf", 64'(a_zf), 64'h1);
      chk("sub_cc_sf", 64'(a_sf), 64'h0);
      chk("sub_cc_of", 64'(a_of), 64'h0);

      drive_a(2'b00, 4'h2, 4'h4, 64'h55, '0, '0, 4'h5, 4'hF);
      #1;
      chk("cmovne_e_dstE", 64'(a_e_dstE), 64'hF);
      chk("cmovne_e_valE", a_e_valE, 64'h55);
      step();
      chk("cmovne_M_dstE", 64'(a_M_dstE), 64'hF);
      chk("cmovne_M_valA", a_M_valA, 64'h55);

      drive_a(2'b00, 4'hA, 4'h0, 64'h77, 64'h100, '0, 4'h4, 4'hF);
      #1;
      chk("push_e_valE", a_e_valE, 64'hF8);
      step();
      chk("push_M_valE", a_M_valE, 64'hF8);
      chk("push_M_dstE", 64'(a_M_dstE), 64'h4);

      a_M_stall = 1'b1;
      drive_a(2'b00, 4'hB, 4'h0, '0, 64'h200, '0, 4'h4, 4'h6);
      step();
      step();
      chk("stall_M_valE", a_M_valE, 64'hF8);
      chk("stall_M_icode", 64'(a_M_icode), 64'hA);

      // stall wins over bubble, CC still updates from 3-5
      a_M_bubble = 1'b1;
      drive_a(2'b00, 4'h6, 4'h1, 64'h5, 64'h3, '0, 4'h1, 4'hF);
      step();
      chk("stallbub_M_valE", a_M_valE, 64'hF8);
      chk("stallbub_sf", 64'(a_sf), 64'h1);
      chk("stallbub_zf", 64'(a_zf), 64'h0);

      a_M_stall = 1'b0;
      a_set_cc = 1'b0;
      step();
      chk("bubble_M_icode", 64'(a_M_icode), 64'h1);
      chk("bubble_M_dstE", 64'(a_M_dstE), 64'hF);
      chk("bubble_M_valE", a_M_valE, 64'h0);
      a_M_bubble = 1'b0;

      drive_a(2'b00, 4'h7, 4'h7, '0, '0, 64'h40, 4'hF, 4'hF);
      step();
      chk("jbad_M_stat", 64'(a_M_stat), 64'h3);
      chk("jbad_M_cnd", 64'(a_M_cnd), 64'h0);

`ifndef EXEC_MUL_EN
      a_set_cc = 1'b1;
      drive_a(2'b00, 4'h6, 4'h4, 64'h0, 64'h0, '0, 4'h2, 4'hF);
      step();
      chk("op4_M_stat", 64'(a_M_stat), 64'h3);
      chk("op4_M_dstE", 64'(a_M_dstE), 64'hF);
      chk("op4_zf", 64'(a_zf), 64'h0);
      a_set_cc = 1'b0;
`endif

      drive_a(2'b01, 4'h3, 4'h0, '0, '0, 64'h1234, 4'h7, 4'hF);
      step();
      chk("hlt_M_stat", 64'(a_M_stat), 64'h1);
      chk("hlt_M_valE", a_M_valE, 64'h1234);

      // W=16 xor and invalid OPq
      b_set_cc = 1'b1;
      drive_b(2'b00, 4'h6, 4'h3, 16'h00FF, 16'hFFFF, 4'h2);
      #1;
      chk("w16_xor_e_valE", 64'(b_e_valE), 64'hFF00);
      step();
      chk("w16_xor_M_valE", 64'(b_M_valE), 64'hFF00);
      chk("w16_xor_sf", 64'(b_sf), 64'h1);
      chk("w16_xor_of", 64'(b_of), 64'h0);
      chk("w16_xor_zf", 64'(b_zf), 64'h0);
      drive_b(2'b00, 4'h6, 4'h7, 16'h0, 16'h0, 4'h1);
      step();
      chk("w16_bad_M_stat", 64'(b_M_stat), 64'h3);
      chk("w16_bad_M_dstE", 64'(b_M_dstE), 64'hF);
      chk("w16_bad_zf", 64'(b_zf), 64'h0);
      chk("w16_bad_sf", 64'(b_sf), 64'h1);

`ifdef EXEC_MUL_EN
      a_set_cc = 1'b1;
      drive_a(2'b00, 4'h6, 4'h4, 64'd7, 64'd6, '0, 4'h3, 4'hF);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mul_busy", 64'(a_e_busy), 64'h1);
         step();
         chk("mul_bubble_icode", 64'(a_M_icode), 64'h1);
      end
      #1;
      chk("mul_last_busy", 64'(a_e_busy), 64'h0);
      step();
      chk("mul_M_valE", a_M_valE, 64'd42);
      chk("mul_zf", 64'(a_zf), 64'h0);
      chk("mul_sf", 64'(a_sf), 64'h0);
      drive_a(2'b00, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
      step();
      drive_a(2'b00, 4'h6, 4'h4, 64'd7, 64'd6, '0, 4'h3, 4'hF);
      step();
      rst = 1'b1;
      drive_a(2'b00, 4'h1, 4'h0, '0, '0, '0, 4'hF, 4'hF);
      step();
      rst = 1'b0;
      chk("mulrst_busy", 64'(a_e_busy), 64'h0);
      chk("mulrst_zf", 64'(a_zf), 64'h1);
      chk("mulrst_M_icode", 64'(a_M_icode), 64'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
